// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the uart_tx sharing logic.
//   CLKS_PER_BIT     : uart_tx bit period in system clocks.
//   NUM_REQ_DEFAULT  : default number of byte producers.
//   IDX_W_DEFAULT    : default requester index width (clog2 of NUM_REQ_DEFAULT).
//   arb_state_t      : arbiter FSM state encoding (3 bits).
//   wrap_idx         : single-step modulo wrap for index arithmetic.
package uart_pkg;

  localparam int CLKS_PER_BIT    = 87;
  localparam int NUM_REQ_DEFAULT = 4;
  localparam int IDX_W_DEFAULT   = 2;

  typedef enum logic [2:0] {
    ST_SYNC      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DRAIN     = 3'd4
  } arb_state_t;

  // Callers guarantee value < 2*modulus, so one subtraction is enough.
  function automatic int wrap_idx(input int value, input int modulus);
    return (value >= modulus) ? (value - modulus) : value;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational requester selection.
//   req        in  NUM_REQ  request vector
//   ptr        in  IDX_W    index of the last granted requester
//   fixed_prio in  1        1: lowest set index wins, ptr ignored
//   valid      out 1        at least one request is set
//   idx        out IDX_W    chosen requester
// Round-robin search starts at ptr+1 and wraps modulo NUM_REQ.
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int IDX_W   = IDX_W_DEFAULT
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               fixed_prio,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int start;
  int cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    start = fixed_prio ? 0 : wrap_idx(int'(ptr) + 1, NUM_REQ);
    cand  = 0;
    // Visit candidates in priority order; the first set request wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = wrap_idx(start + i, NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!valid && (j == cand) && req[j]) begin
          valid = 1'b1;
          idx   = j[IDX_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte producers.
// One byte is accepted per grant; the byte is handed to uart_tx with a
// single-cycle DV pulse and the owner gets a done pulse once the stop bit
// has finished.
//
// Ports:
//   i_Clock     in  1          system clock (same domain as uart_tx)
//   i_Reset     in  1          asynchronous active-high reset
//   i_Req       in  NUM_REQ    per-requester request, held until granted
//   i_Req_Byte  in  8*NUM_REQ  requester k byte at [8k+7:8k]
//   o_Grant     out NUM_REQ    one-hot pulse: byte accepted
//   o_Done      out NUM_REQ    one-hot pulse: granted byte fully sent
//   o_Busy      out 1          state is not IDLE
//   o_Tx_DV     out 1          to uart_tx i_Tx_DV
//   o_Tx_Byte   out 8          to uart_tx i_Tx_Byte
//   i_Tx_Active in  1          from uart_tx o_Tx_Active
//   i_Tx_Done   in  1          from uart_tx o_Tx_Done (2 cycles per byte)
//   dbg_state   out 3          current FSM state (arb_state_t encoding)
//
// Build option: define UART_TX_ARB_FIXED_PRIO_EN for fixed priority
// (lowest requester index always wins). Default build is round-robin.
//
// Handshake: a requester holds i_Req high with its byte stable; the byte is
// taken in the cycle o_Grant shows its bit, after which i_Req may drop.
// IDX_W must equal clog2(NUM_REQ).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int IDX_W   = IDX_W_DEFAULT
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic [NUM_REQ-1:0]   o_Done,
  output logic                 o_Busy,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic [2:0]           dbg_state
);

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  arb_state_t         state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   cur_idx, cur_n;
  logic               tx_done_q;
  logic [NUM_REQ-1:0] grant_n, done_n;
  logic               dv_n, busy_n;
  logic [7:0]         byte_n, req_byte;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               done_edge;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (i_Req),
    .ptr        (ptr),
    .fixed_prio (FIXED_PRIO),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  // Byte mux for the selected requester.
  always_comb begin
    req_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == k[IDX_W-1:0]) req_byte = i_Req_Byte[8*k +: 8];
    end
  end

  // A Done level already present when WAIT_DONE is entered has a high
  // registered copy, so it is not treated as an edge.
  assign done_edge = i_Tx_Done & ~tx_done_q;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cur_n   = cur_idx;
    grant_n = '0;
    done_n  = '0;
    dv_n    = 1'b0;
    byte_n  = o_Tx_Byte;
    case (state)
      // uart_tx is not reset with us; wait for it to be quiet.
      ST_SYNC: begin
        if (!i_Tx_Active && !i_Tx_Done) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (pick_valid) begin
          state_n = ST_ISSUE;
          dv_n    = 1'b1;
          byte_n  = req_byte;
          cur_n   = pick_idx;
          ptr_n   = pick_idx;
          for (int k = 0; k < NUM_REQ; k++) begin
            grant_n[k] = (pick_idx == k[IDX_W-1:0]);
          end
        end
      end
      ST_ISSUE: begin
        state_n = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done_edge) begin
          state_n = ST_DRAIN;
          for (int k = 0; k < NUM_REQ; k++) begin
            done_n[k] = (cur_idx == k[IDX_W-1:0]);
          end
        end
      end
      // Let the uart_tx cleanup cycle finish before the next DV.
      ST_DRAIN: begin
        if (!i_Tx_Done && !i_Tx_Active) state_n = ST_IDLE;
      end
      default: state_n = ST_SYNC;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state     <= ST_SYNC;
      ptr       <= IDX_W'(NUM_REQ - 1);
      cur_idx   <= '0;
      tx_done_q <= 1'b0;
      o_Grant   <= '0;
      o_Done    <= '0;
      o_Busy    <= 1'b0;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cur_idx   <= cur_n;
      tx_done_q <= i_Tx_Done;
      o_Grant   <= grant_n;
      o_Done    <= done_n;
      o_Busy    <= busy_n;
      o_Tx_DV   <= dv_n;
      o_Tx_Byte <= byte_n;
    end
  end

  assign dbg_state = state;

endmodule
